// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and the 64-bit Fibonacci LFSR step used by the draw arbiter
package lfsr_pkg;
    typedef enum logic [1:0] {IDLE, STEP, GRANT} draw_state_t;
    localparam int LFSR_W = 64;
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction
endpackage

// File: rtl/lfsr_draw_arbiter_if.sv
// lfsr_draw_arbiter_if: requester-side bus of the shared LFSR draw arbiter
interface lfsr_draw_arbiter_if
    import lfsr_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [LFSR_W-1:0] seed;
    logic seed_load;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack;
    logic [LFSR_W-1:0] rnd_data;
    logic [$clog2(N_REQ)-1:0] owner;
    logic busy;
    modport master (output seed, seed_load, req, input ack, rnd_data, owner, busy);
    modport slave (input seed, seed_load, req, output ack, rnd_data, owner, busy);
endinterface

// File: rtl/lfsr_draw_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or above ptr with wraparound
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [$clog2(N_REQ)-1:0] idx
);
    localparam int IW = $clog2(N_REQ);
    logic [IW-1:0] j;
    always_comb begin
        idx = '0;
        j = '0;
        // walk offsets from farthest to nearest so the nearest set request wins
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % N_REQ);
            if (req[j]) idx = j;
        end
        grant = |req ? {{(N_REQ - 1){1'b0}}, 1'b1} << idx : '0;
    end
endmodule

// File: rtl/lfsr_draw_arbiter.sv
// lfsr_draw_arbiter: shares one 64-bit LFSR among requesters, round-robin, multi-step draws
// with reseed taking priority over any draw in flight.
module lfsr_draw_arbiter
    import lfsr_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int STEPS_PER_DRAW = 8,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 64'hACE1_0000_0000_0001
) (
    input logic clk,
    input logic reset,
    lfsr_draw_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = STEPS_PER_DRAW > 1 ? $clog2(STEPS_PER_DRAW) : 1;
    draw_state_t state, state_nx;
    logic [LFSR_W-1:0] lfsr, rnd_data;
    logic [CW-1:0] cnt;
    logic [IW-1:0] rr_ptr, owner, pick_idx;
    logic [N_REQ-1:0] pick_oh, owner_oh, ack;
    logic arb, last_step;

    rr_pick #(.N_REQ(N_REQ)) u_pick (.req(bus.req), .ptr(rr_ptr), .grant(pick_oh), .idx(pick_idx));

    always_comb begin
        arb = state == IDLE && |bus.req && !bus.seed_load;
        last_step = state == STEP && cnt == '0 && !bus.seed_load;
        state_nx = bus.seed_load ? IDLE : arb ? STEP : last_step ? GRANT : state == GRANT ? IDLE : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            lfsr <= DEFAULT_SEED;
            cnt <= '0;
            rr_ptr <= '0;
            owner <= '0;
            owner_oh <= '0;
            ack <= '0;
            rnd_data <= '0;
        end else begin
            state <= state_nx;
            // a zero seed would lock the LFSR at zero forever
            if (bus.seed_load) lfsr <= bus.seed == '0 ? DEFAULT_SEED : bus.seed;
            else if (state == STEP) lfsr <= lfsr_next(lfsr);
            if (arb) begin
                owner <= pick_idx;
                owner_oh <= pick_oh;
                cnt <= CW'(STEPS_PER_DRAW - 1);
            end else if (state == STEP) begin
                cnt <= cnt - 1'b1;
            end
            if (state == GRANT) rr_ptr <= owner == IW'(N_REQ - 1) ? '0 : owner + 1'b1;
            ack <= last_step ? owner_oh : '0;
            rnd_data <= last_step ? lfsr_next(lfsr) : '0;
        end
    end

    assign bus.ack = ack;
    assign bus.rnd_data = rnd_data;
    assign bus.owner = owner;
    assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_lfsr_draw_arbiter.sv
// tb_lfsr_draw_arbiter: directed draws with a scoreboard queue checked by an ack monitor
module tb_lfsr_draw_arbiter;
    localparam int N = 4;
    localparam int STEPS = 8;
    localparam logic [63:0] DSEED = 64'hACE1_0000_0000_0001;
    typedef struct {
        logic [N-1:0] ack;
        logic [63:0] data;
        logic [1:0] idx;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];
    exp_t e;
    logic [63:0] m;

    lfsr_draw_arbiter_if #(.N_REQ(N)) bus ();
    lfsr_draw_arbiter #(.N_REQ(N), .STEPS_PER_DRAW(STEPS), .DEFAULT_SEED(DSEED)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] draw(input logic [63:0] s);
        for (int i = 0; i < STEPS; i++) s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Ack is seen at the negedge 9 cycles after the negedge where the request was driven.
    task automatic push(input int idx, input logic [63:0] data, input int at);
        exp_t x;
        x.ack = 4'b0001 << idx;
        x.data = data;
        x.idx = 2'(idx);
        x.cyc = at;
        q.push_back(x);
    endtask

    task automatic push_model(input int idx, input int at);
        m = draw(m);
        push(idx, m, at);
    endtask

    task automatic wait_ack(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(|bus.ack) && k < 14);
        n_cmp++;
        if (!(|bus.ack)) begin
            n_bad++;
            $display("FAIL %s: no ack within %0d cycles", name, k);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("rst_ack", 64'(bus.ack), 0);
        check("rst_rnd", bus.rnd_data, 0);
        check("rst_owner", 64'(bus.owner), 0);
        check("rst_busy", 64'(bus.busy), 0);
        reset = 1'b0;
        m = DSEED;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (|bus.ack) begin
                if (q.size() == 0) begin
                    check("unexpected_ack", 64'(bus.ack), 0);
                end else begin
                    e = q.pop_front();
                    check("ack", 64'(bus.ack), 64'(e.ack));
                    check("rnd_data", bus.rnd_data, e.data);
                    check("owner", 64'(bus.owner), 64'(e.idx));
                    check("ack_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                check("rnd_idle_zero", bus.rnd_data, 0);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = '0;
        bus.seed = '0;
        bus.seed_load = 1'b0;
        // 1: seed 1, two draws by requester 0 give hand-computed shifts
        do_reset();
        bus.seed = 64'h1;
        bus.seed_load = 1'b1;
        @(negedge clk);
        bus.seed_load = 1'b0;
        bus.req = 4'b0001;
        push(0, 64'h100, cyc + 9);
        push(0, 64'h10000, cyc + 19);
        @(negedge clk);
        check("busy_in_step", 64'(bus.busy), 1);
        wait_ack("t1_first");
        wait_ack("t1_second");
        bus.req = '0;
        // 2: saturated requesters served in index order, one draw every 10 cycles
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) push_model(k % N, cyc + 9 + 10 * k);
        for (int k = 0; k < 5; k++) wait_ack("t2_sat");
        bus.req = '0;
        // 3: zero seed falls back to the default seed
        @(negedge clk);
        bus.seed = 64'h0;
        bus.seed_load = 1'b1;
        @(negedge clk);
        bus.seed_load = 1'b0;
        m = DSEED;
        bus.req = 4'b0010;
        push_model(1, cyc + 9);
        wait_ack("t3_zero_seed");
        bus.req = '0;
        // 4: reseed mid-step aborts silently; round-robin pointer keeps requester 3 first
        @(negedge clk);
        bus.req = 4'b1001;
        repeat (3) @(negedge clk);
        bus.seed = 64'h1;
        bus.seed_load = 1'b1;
        bus.req = '0;
        @(negedge clk);
        bus.seed_load = 1'b0;
        check("abort_busy", 64'(bus.busy), 0);
        check("abort_ack", 64'(bus.ack), 0);
        bus.req = 4'b1001;
        push(3, 64'h100, cyc + 9);
        m = 64'h100;
        wait_ack("t4_redraw");
        bus.req = '0;
        // 5: asynchronous reset mid-step clears outputs without waiting for an edge
        @(negedge clk);
        bus.req = 4'b0100;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy", 64'(bus.busy), 1);
        check("pre_rst_owner", 64'(bus.owner), 2);
        reset = 1'b1;
        #1;
        check("async_ack", 64'(bus.ack), 0);
        check("async_busy", 64'(bus.busy), 0);
        check("async_owner", 64'(bus.owner), 0);
        bus.req = '0;
        @(negedge clk);
        reset = 1'b0;
        m = DSEED;
        // 6: request dropped after arbitration still completes with one ack
        bus.req = 4'b0100;
        push_model(2, cyc + 9);
        @(negedge clk);
        @(negedge clk);
        bus.req = '0;
        wait_ack("t6_dropped");
        @(negedge clk);
        check("t6_idle", 64'(bus.busy), 0);
        repeat (12) @(negedge clk);
        check("queue_empty", 64'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
